fp16_add_requester: RTL and testbench
=====================================

// Module: fp16_add_requester
// PURPOSE
//  Initiator side of the half-precision adder start/ready protocol (add, number1, number2 -> result, ready).
//  Buffers operand pairs from an upstream valid/ready stream and issues them one at a time to floating_point_adder.
//  Returns each sum on a downstream valid/ready stream, in issue order.
//  Sits between the datapath sequencer and the adder; the adder itself is not modified.
// PARAMETERS
//  DEPTH    4   operand-pair FIFO entries; power of 2, >=2
//  TIMEOUT  64  cycles to wait for ready before abort; used only with FP16_REQ_TIMEOUT_EN
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   operand pair valid
//  in_ready    out  1   FIFO not full
//  in_a        in   16  fp16 operand A {sign,exp[4:0],man[9:0]}
//  in_b        in   16  fp16 operand B
//  out_valid   out  1   sum valid
//  out_ready   in   1   downstream accepts sum
//  out_result  out  16  fp16 sum
//  out_err     out  1   sum aborted by timeout; qualified by out_valid
//  add         out  1   start request to adder
//  number1     out  16  operand A to adder
//  number2     out  16  operand B to adder
//  result      in   16  adder sum
//  ready       in   1   adder done
//  busy        out  1   FSM not IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, add=0, number1=number2=0, out_valid=0, out_result=0, out_err=0, busy=0; in_ready=1 from the first cycle after reset.
//  FIFO push: in_valid&&in_ready. Pop: IDLE with FIFO non-empty. Push and pop in the same cycle are both allowed when full.
//  Full: in_ready=0. Pointers wrap modulo DEPTH, with an extra bit for full/empty.
//  FSM states: IDLE -> ISSUE -> CAPTURE -> DRAIN -> OUTPUT -> IDLE.
//  IDLE: FIFO non-empty -> pop and latch number1/number2; add=1 from the next cycle (ISSUE). The first add occurs 2 cycles after the first push into an empty FIFO.
//  ISSUE: add held 1 and number1/number2 held stable until ready=1 is sampled -> CAPTURE.
//  CAPTURE: latch result into out_result; add=0 -> DRAIN.
//  DRAIN: wait for ready=0; this prevents double-counting a level-held ready -> OUTPUT.
//  OUTPUT: out_valid=1; out_result and out_err stable until out_ready; on handshake -> IDLE.
//  Back-to-back: the next pop occurs in the IDLE cycle after the OUTPUT handshake. There is no overlap of requests.
//  number1/number2 keep their last values after a request completes and are never re-driven mid-request.
//  rst mid-request: add drops to 0 next cycle; FIFO is flushed; an in-flight sum is discarded; the adder's late ready is ignored while in IDLE.
//  ready=1 while IDLE or OUTPUT: ignored.
// CONFIGURATION
//  FP16_REQ_TIMEOUT_EN defined:
//   - Cycle counter runs in ISSUE and DRAIN.
//   - Reaching TIMEOUT -> add=0, out_result=16'h7E00 (qNaN), out_err=1, go to OUTPUT.
//   - The counter clears on every state entry.
//  Undefined: no counter; wait indefinitely; out_err is tied 0.
// STRUCTURE
//  Package fp16_req_pkg:
//   - fp16 field widths (EXP_W=5, MAN_W=10, W=16)
//   - FSM state enum (3-bit)
//   - FP16_QNAN=16'h7E00
//  Sub-module fp16_req_fifo: synchronous FIFO, 32-bit entries {a,b}, depth DEPTH, full/empty flags.
//  Top level holds the FSM, output registers and the optional watchdog.
// TESTING
//  Bench drives an adder response model: ready rises 5 cycles after add, falls 1 cycle after add drops.
//  1. Push {4B10,D0EC}; model returns CE50 -> one add pulse; number1=4B10, number2=D0EC; out_result=CE50, out_err=0.
//  2. Push {3800,3800} with out_ready held 0 for 10 cycles -> out_valid stays 1; out_result=3C00 stable; no second add.
//  3. Push 5 pairs back-to-back with DEPTH=4 -> in_ready low after the 4th is buffered (1 in flight); all 5 sums out in order.
//  4. Model holds ready high for 8 cycles -> exactly one out_valid handshake for that request.
//  5. Assert rst for 1 cycle during ISSUE -> add=0 next cycle; busy=0; out_valid=0; the late ready produces no output.
//  6. With FP16_REQ_TIMEOUT_EN and a model that never readies -> 64 cycles after add rises, out_result=7E00 and out_err=1.

Source files
------------

// File: rtl/fp16_req_pkg.sv
// Shared types and constants for the fp16 adder requester.
// Field widths, FSM state encoding and the timeout sum value.
package fp16_req_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int W     = 1 + EXP_W + MAN_W;

    localparam logic [W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DRAIN,
        S_OUTPUT
    } state_e;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

endpackage

// File: rtl/fp16_add_requester_if.sv
// Operand stream, sum stream and adder start/ready bundle.
// slave: requester side; master: sequencer, sink and adder side.
interface fp16_add_requester_if;
    import fp16_req_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_err;
    logic         add;
    logic [W-1:0] number1;
    logic [W-1:0] number2;
    logic [W-1:0] result;
    logic         ready;
    logic         busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, result, ready,
        output in_ready, out_valid, out_result, out_err,
        output add, number1, number2, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, result, ready,
        input  in_ready, out_valid, out_result, out_err,
        input  add, number1, number2, busy
    );

endinterface

// File: rtl/fp16_req_fifo.sv
// Operand-pair FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a counter.
module fp16_req_fifo
    import fp16_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  logic  pop_i,
    input  pair_t wdata_i,
    output pair_t rdata_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    pair_t       mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        push_ok, pop_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign wr_d = push_ok ? wr_q + ONE : wr_q;
    assign rd_d = pop_ok  ? rd_q + ONE : rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fp16_add_requester.sv
// Issues buffered fp16 operand pairs to the adder one at a time.
// Define FP16_REQ_TIMEOUT_EN to abort stalled requests with a qNaN.
module fp16_add_requester
    import fp16_req_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 rst,
    fp16_add_requester_if.slave bus
);

    state_e       state_q, state_d;
    logic [W-1:0] n1_q, n1_d;
    logic [W-1:0] n2_q, n2_d;
    logic [W-1:0] res_q, res_d;
    logic         err_q, err_d;
    logic         full, empty, push, pop;
    logic         to_hit;
    pair_t        wdata, rdata;

    assign wdata = '{a: bus.in_a, b: bus.in_b};
    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = (state_q == S_IDLE) && !empty;

    fp16_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef FP16_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign to_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Restarts on every state change; only advances while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_ISSUE ||
                     state_q == S_DRAIN) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    n1_d    = rdata.a;
                    n2_d    = rdata.b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.ready) begin
                    state_d = S_CAPTURE;
                end else if (to_hit) begin
                    res_d   = FP16_QNAN;
                    err_d   = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_CAPTURE: begin
                res_d   = bus.result;
                err_d   = 1'b0;
                state_d = S_DRAIN;
            end
            // A level-held ready must fall before the sum is offered.
            S_DRAIN: begin
                if (!bus.ready) begin
                    state_d = S_OUTPUT;
                end else if (to_hit) begin
                    res_d   = FP16_QNAN;
                    err_d   = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n1_q    <= '0;
            n2_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.add        = (state_q == S_ISSUE);
    assign bus.number1    = n1_q;
    assign bus.number2    = n2_q;
    assign bus.out_valid  = (state_q == S_OUTPUT);
    assign bus.out_result = res_q;
    assign bus.out_err    = err_q;
    assign bus.busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_fp16_add_requester.sv
// Scoreboard bench: real-arithmetic fp16 reference, adder responder,
// operand-issue and sum monitors.
module tb_fp16_add_requester;
    import fp16_req_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp16_add_requester_if bus();

    fp16_add_requester #(
        .DEPTH   (4),
        .TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] r;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] iss_q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int add_count = 0;
    int add_rise_cyc = 0;
    bit stall = 1'b0;
    bit respond = 1'b1;
    bit late_go = 1'b0;
    int hold_cfg = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) v = real'(h[9:0]) * (2.0 ** -24);
        else v = (1024.0 + real'(h[9:0])) * (2.0 ** (e - 25));
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        logic s;
        real  v, fr, rem;
        int   e, mi;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        v = s ? -x : x;
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        fr  = (v - 1.0) * 1024.0;
        mi  = $rtoi(fr);
        rem = fr - real'(mi);
        if (rem > 0.5 || (rem == 0.5 && mi % 2 == 1)) mi++;
        if (mi == 1024) begin mi = 0; e++; end
        return {s, 5'(e), 10'(mi)};
    endfunction

    function automatic logic [15:0] ref_add(
        input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] rnd_h();
        logic [15:0] h;
        h[15]    = 1'($urandom_range(1));
        h[14:10] = 5'($urandom_range(20, 14));
        h[9:0]   = 10'($urandom_range(1023));
        return h;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic bad(input string msg);
        tests++;
        fails++;
        $display("FAIL %s", msg);
    endtask

    // Adder responder: ready about 5 cycles into add, drops after add.
    initial begin
        int cnt, hold, late_n;
        bit late_used;
        cnt = 0; hold = 0; late_n = 0; late_used = 1'b0;
        bus.ready  = 1'b0;
        bus.result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (late_go && !late_used) begin
                late_used = 1'b1;
                late_n = 4;
            end
            if (late_n > 0) begin
                bus.ready = 1'b1;
                late_n--;
                hold = 0;
            end else if (bus.add) begin
                if (!bus.ready) begin
                    cnt++;
                    if (cnt >= 5 && respond) begin
                        bus.ready  = 1'b1;
                        bus.result = ref_add(bus.number1, bus.number2);
                        hold = hold_cfg;
                    end
                end
            end else begin
                cnt = 0;
                if (bus.ready) begin
                    if (hold > 0) hold--;
                    else bus.ready = 1'b0;
                end
            end
        end
    end

    // Monitor: operand issue order and sum order.
    initial begin
        logic [31:0] held;
        logic        prev;
        exp_t        e;
        held = '0;
        prev = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.out_ready = stall ? 1'b0 : ($urandom_range(3) != 0);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bus.add && !prev) begin
                    add_count++;
                    add_rise_cyc = cyc;
                    if (iss_q.size() == 0) begin
                        bad($sformatf("spurious_add: got %h%h required none",
                            bus.number1, bus.number2));
                    end else begin
                        held = iss_q.pop_front();
                        chk("issue_operands",
                            {bus.number1, bus.number2}, held);
                    end
                end else if (bus.add) begin
                    chk("operand_hold", {bus.number1, bus.number2}, held);
                end
                prev = bus.add;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        bad($sformatf("spurious_out: got %h required none",
                            bus.out_result));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_result", 32'(bus.out_result), 32'(e.r));
                        chk("out_err", 32'(bus.out_err), 32'(e.e));
                    end
                end
            end
        end
    end

    task automatic push(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic terr);
        int   g;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        g = 0;
        while (!bus.in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            bad($sformatf("push_wait: in_ready %b after %0d cycles, required 1",
                bus.in_ready, g));
        end else begin
            e.r = terr ? FP16_QNAN : ref_add(a, b);
            e.e = terr;
            exp_q.push_back(e);
            iss_q.push_back({a, b});
            @(posedge clk);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || bus.busy) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000)
            bad($sformatf("%s: %0d sums pending after %0d cycles, required 0",
                name, exp_q.size(), g));
    endtask

    task automatic wait_valid(input string name);
        int g;
        g = 0;
        while (!bus.out_valid && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!bus.out_valid)
            bad($sformatf("%s: out_valid 0 after %0d cycles, required 1",
                name, g));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, required finish", $time);
        $fatal(1);
    end

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_add", 32'(bus.add), 0);
        chk("rst_number1", 32'(bus.number1), 0);
        chk("rst_number2", 32'(bus.number2), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_result", 32'(bus.out_result), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        base = add_count;
        push(16'h4B10, 16'hD0EC, 1'b0);
        chk("t1_model_sum", 32'(exp_q[0].r), 32'h0000CE50);
        idle_in();
        wait_idle("t1_drain");
        chk("t1_add_pulses", add_count - base, 1);

        stall = 1'b1;
        push(16'h3800, 16'h3800, 1'b0);
        idle_in();
        wait_valid("t2_valid");
        base = add_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(bus.out_valid), 1);
            chk("t2_hold_result", 32'(bus.out_result), 32'h00003C00);
        end
        chk("t2_no_second_add", add_count - base, 0);
        stall = 1'b0;
        wait_idle("t2_drain");

        stall = 1'b1;
        for (int i = 0; i < 5; i++) push(rnd_h(), rnd_h(), 1'b0);
        idle_in();
        chk("t3_full_in_ready", 32'(bus.in_ready), 0);
        chk("t3_busy", 32'(bus.busy), 1);
        stall = 1'b0;
        wait_idle("t3_drain");

        hold_cfg = 8;
        base = add_count;
        push(rnd_h(), rnd_h(), 1'b0);
        idle_in();
        wait_idle("t4_drain");
        chk("t4_add_pulses", add_count - base, 1);
        hold_cfg = 0;

        push(rnd_h(), rnd_h(), 1'b0);
        idle_in();
        for (int g = 0; g < 50 && !bus.add; g++) @(negedge clk);
        chk("t5_in_issue", 32'(bus.add), 1);
        rst = 1'b1;
        exp_q.delete();
        iss_q.delete();
        @(posedge clk);
        #1;
        chk("t5_add_drop", 32'(bus.add), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        late_go = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_late_ready_ignored",
                {bus.out_valid, bus.add, bus.busy}, 0);
        end

        for (int n = 0; n < 20; n++) begin
            hold_cfg = $urandom_range(3);
            push(rnd_h(), rnd_h(), 1'b0);
            if ($urandom_range(1) == 1) begin
                idle_in();
                repeat ($urandom_range(6)) @(negedge clk);
            end
        end
        idle_in();
        wait_idle("rand_drain");
        hold_cfg = 0;

`ifdef FP16_REQ_TIMEOUT_EN
        stall = 1'b1;
        respond = 1'b0;
        push(16'h3C00, 16'h4000, 1'b1);
        idle_in();
        wait_valid("t6_valid");
        chk("t6_latency", cyc - add_rise_cyc, 64);
        chk("t6_result", 32'(bus.out_result), 32'h00007E00);
        chk("t6_err", 32'(bus.out_err), 1);
        stall = 1'b0;
        wait_idle("t6_drain");
        respond = 1'b1;
`endif

        repeat (4) @(negedge clk);
        chk("end_sums_pending", exp_q.size(), 0);
        chk("end_issues_pending", iss_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
